// File: rtl/kf8259_common_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kf8259_common_pkg
// Purpose  : Shared OCW2 command encoding and bit-vector helpers for KF8259.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package kf8259_common_pkg;

  localparam int MAX_LEVELS = 32;
  localparam int MAX_LEVEL_W = 5;

  // OCW2 command field, bit order {R, SL, EOI}
  typedef enum logic [2:0] {
    OCW2_CLEAR_ROTATE_AEOI = 3'b000,
    OCW2_NON_SPECIFIC_EOI  = 3'b001,
    OCW2_NOP               = 3'b010,
    OCW2_SPECIFIC_EOI      = 3'b011,
    OCW2_SET_ROTATE_AEOI   = 3'b100,
    OCW2_ROTATE_NS_EOI     = 3'b101,
    OCW2_SET_PRIORITY      = 3'b110,
    OCW2_ROTATE_SPEC_EOI   = 3'b111
  } ocw2_cmd_e;

  // result[i] = value[(i + n) mod width]; width must be a power of two
  function automatic logic [MAX_LEVELS-1:0] rotate_right(
    input logic [MAX_LEVELS-1:0] value,
    input int                    width,
    input int                    n
  );
    logic [MAX_LEVELS-1:0] result;
    result = '0;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (i < width) result[i] = value[(i + n) & (width - 1)];
    end
    return result;
  endfunction

  // result[(i + n) mod width] = value[i]; inverse of rotate_right
  function automatic logic [MAX_LEVELS-1:0] rotate_left(
    input logic [MAX_LEVELS-1:0] value,
    input int                    width,
    input int                    n
  );
    logic [MAX_LEVELS-1:0] result;
    result = '0;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (i < width) result[(i + n) & (width - 1)] = value[i];
    end
    return result;
  endfunction

  function automatic logic [MAX_LEVEL_W-1:0] onehot_to_index(
    input logic [MAX_LEVELS-1:0] value
  );
    logic [MAX_LEVEL_W-1:0] index;
    index = '0;
    for (int i = 0; i < MAX_LEVELS; i++) begin
      if (value[i]) index = index | MAX_LEVEL_W'(i);
    end
    return index;
  endfunction

endpackage : kf8259_common_pkg
`default_nettype wire

// File: rtl/kf8259_priority_resolver.sv
`default_nettype none
// ============================================================================
// Module   : kf8259_priority_resolver
// Purpose  : Picks the highest-priority set bit of a request vector under a
//            rotating priority where priority_rotate names the lowest level.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module kf8259_priority_resolver
  import kf8259_common_pkg::*;
#(
  parameter  int NUM_LEVELS = 8,
  localparam int LEVEL_W    = $clog2(NUM_LEVELS)
) (
  input  logic [NUM_LEVELS-1:0] request,
  input  logic [LEVEL_W-1:0]    priority_rotate,
  output logic [NUM_LEVELS-1:0] highest
);

  logic [NUM_LEVELS-1:0] w_rotated;
  logic [NUM_LEVELS-1:0] w_lowest;
  int                    w_shift;

  // After rotating, bit 0 holds the highest-ranked level
  assign w_shift   = int'(priority_rotate) + 1;
  assign w_rotated = NUM_LEVELS'(rotate_right(MAX_LEVELS'(request), NUM_LEVELS, w_shift));
  assign w_lowest  = w_rotated & (-w_rotated);
  assign highest   = NUM_LEVELS'(rotate_left(MAX_LEVELS'(w_lowest), NUM_LEVELS, w_shift));

endmodule : kf8259_priority_resolver
`default_nettype wire

// File: rtl/kf8259_in_service_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kf8259_in_service_ctrl
// Purpose  : In-service register, rotating priority pointer and OCW2/AEOI
//            end-of-interrupt handling for NUM_LEVELS interrupt levels.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module kf8259_in_service_ctrl
  import kf8259_common_pkg::*;
#(
  parameter  int NUM_LEVELS = 8,
  localparam int LEVEL_W    = $clog2(NUM_LEVELS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_LEVELS-1:0] interrupt,
  input  logic                  start_in_service,
  input  logic                  end_of_acknowledge_sequence,
  input  logic                  auto_eoi_mode,
  input  logic                  ocw2_write,
  input  logic [2:0]            ocw2_cmd,
  input  logic [LEVEL_W-1:0]    ocw2_level,
  output logic [NUM_LEVELS-1:0] in_service_register,
  output logic [NUM_LEVELS-1:0] highest_level_in_service,
  output logic [LEVEL_W-1:0]    priority_rotate,
  output logic                  rotate_in_auto_eoi,
  output logic                  eoi_error
);

  logic [NUM_LEVELS-1:0] r_isr;
  logic [NUM_LEVELS-1:0] r_last_acked;
  logic [LEVEL_W-1:0]    r_priority_rotate;
  logic                  r_rotate_in_auto_eoi;
  logic                  r_eoi_error;

  logic [NUM_LEVELS-1:0] w_highest;
  logic [NUM_LEVELS-1:0] w_level_onehot;
  logic [LEVEL_W-1:0]    w_highest_index;
  logic [LEVEL_W-1:0]    w_last_acked_index;
  ocw2_cmd_e             w_cmd;

  logic [NUM_LEVELS-1:0] w_ocw_clear;
  logic                  w_ocw_error;
  logic                  w_ocw_rotate;
  logic [LEVEL_W-1:0]    w_ocw_rotate_level;
  logic                  w_set_rotate_aeoi;
  logic                  w_clear_rotate_aeoi;

  logic                  w_aeoi_active;
  logic [NUM_LEVELS-1:0] w_aeoi_clear;
  logic                  w_aeoi_rotate;
  logic [NUM_LEVELS-1:0] w_set;
  logic [NUM_LEVELS-1:0] w_isr_next;

  kf8259_priority_resolver #(
    .NUM_LEVELS (NUM_LEVELS)
  ) u_isr_resolver (
    .request         (r_isr),
    .priority_rotate (r_priority_rotate),
    .highest         (w_highest)
  );

  assign w_cmd              = ocw2_cmd_e'(ocw2_cmd);
  assign w_level_onehot     = NUM_LEVELS'(1) << ocw2_level;
  assign w_highest_index    = LEVEL_W'(onehot_to_index(MAX_LEVELS'(w_highest)));
  assign w_last_acked_index = LEVEL_W'(onehot_to_index(MAX_LEVELS'(r_last_acked)));

  always_comb begin
    w_ocw_clear         = '0;
    w_ocw_error         = 1'b0;
    w_ocw_rotate        = 1'b0;
    w_ocw_rotate_level  = ocw2_level;
    w_set_rotate_aeoi   = 1'b0;
    w_clear_rotate_aeoi = 1'b0;
    if (ocw2_write) begin
      case (w_cmd)
        OCW2_NON_SPECIFIC_EOI: begin
          if (w_highest == '0) w_ocw_error = 1'b1;
          else                 w_ocw_clear = w_highest;
        end
        OCW2_SPECIFIC_EOI: begin
          if ((r_isr & w_level_onehot) == '0) w_ocw_error = 1'b1;
          else                                w_ocw_clear = w_level_onehot;
        end
        OCW2_ROTATE_NS_EOI: begin
          if (w_highest == '0) begin
            w_ocw_error = 1'b1;
          end else begin
            w_ocw_clear        = w_highest;
            w_ocw_rotate       = 1'b1;
            w_ocw_rotate_level = w_highest_index;
          end
        end
        OCW2_ROTATE_SPEC_EOI: begin
          if ((r_isr & w_level_onehot) == '0) begin
            w_ocw_error = 1'b1;
          end else begin
            w_ocw_clear  = w_level_onehot;
            w_ocw_rotate = 1'b1;
          end
        end
        OCW2_SET_PRIORITY:      w_ocw_rotate        = 1'b1;
        OCW2_SET_ROTATE_AEOI:   w_set_rotate_aeoi   = 1'b1;
        OCW2_CLEAR_ROTATE_AEOI: w_clear_rotate_aeoi = 1'b1;
        default: ;
      endcase
    end
  end

  // AEOI with nothing acknowledged yet is silently ignored
  assign w_aeoi_active = auto_eoi_mode && end_of_acknowledge_sequence && (r_last_acked != '0);
  assign w_aeoi_clear  = w_aeoi_active ? r_last_acked : '0;
  assign w_aeoi_rotate = w_aeoi_active && r_rotate_in_auto_eoi;

  // Clears come from the pre-edge ISR; a same-cycle set overrides a clear
  assign w_set      = start_in_service ? interrupt : '0;
  assign w_isr_next = (r_isr & ~(w_ocw_clear | w_aeoi_clear)) | w_set;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_isr                <= '0;
      r_last_acked         <= '0;
      r_priority_rotate    <= LEVEL_W'(NUM_LEVELS - 1);
      r_rotate_in_auto_eoi <= 1'b0;
      r_eoi_error          <= 1'b0;
    end else begin
      r_isr       <= w_isr_next;
      r_eoi_error <= w_ocw_error;
      if (start_in_service) r_last_acked <= interrupt;
      if (w_ocw_rotate)       r_priority_rotate <= w_ocw_rotate_level;
      else if (w_aeoi_rotate) r_priority_rotate <= w_last_acked_index;
      if (w_set_rotate_aeoi)        r_rotate_in_auto_eoi <= 1'b1;
      else if (w_clear_rotate_aeoi) r_rotate_in_auto_eoi <= 1'b0;
    end
  end

  assign in_service_register      = r_isr;
  assign highest_level_in_service = w_highest;
  assign priority_rotate          = r_priority_rotate;
  assign rotate_in_auto_eoi       = r_rotate_in_auto_eoi;
  assign eoi_error                = r_eoi_error;

endmodule : kf8259_in_service_ctrl
`default_nettype wire

// File: doc/kf8259_in_service_ctrl.md
Name: kf8259_in_service_ctrl

Overview:
Parametrised in-service register (ISR) controller for the KF8259 interrupt controller, generalising the fixed 8-level in-service block to NUM_LEVELS levels. It owns the ISR, the rotating-priority pointer and the rotate-in-AEOI mode flag, and decodes OCW2-style end-of-interrupt and rotation commands internally. It also handles automatic EOI at the end of the acknowledge sequence. Sits between the interrupt-acknowledge sequencer and the priority resolver, and feeds highest_level_in_service back to both.

Parameters:
NUM_LEVELS, 8, number of interrupt levels; power of two, 2..32
LEVEL_W, $clog2(NUM_LEVELS), width of a level index (derived, not overridden)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
interrupt  in  NUM_LEVELS  one-hot level being acknowledged (all-zero means no-op)
start_in_service  in  1  strobe: set the ISR bit given by interrupt
end_of_acknowledge_sequence  in  1  strobe: last INTA pulse done (drives AEOI)
auto_eoi_mode  in  1  ICW4 AEOI enable (static config)
ocw2_write  in  1  strobe: command on ocw2_cmd/ocw2_level is valid this cycle
ocw2_cmd  in  3  {R,SL,EOI} command code
ocw2_level  in  LEVEL_W  level for specific and set-priority commands
in_service_register  out  NUM_LEVELS  registered ISR
highest_level_in_service  out  NUM_LEVELS  one-hot highest-priority ISR bit (combinational from ISR and priority_rotate), 0 when ISR empty
priority_rotate  out  LEVEL_W  registered lowest-priority level
rotate_in_auto_eoi  out  LEVEL_W-independent 1  registered mode flag
eoi_error  out  1  one-cycle pulse: an EOI cleared nothing

Behaviour:
- Reset values:
  - ISR = 0.
  - priority_rotate = NUM_LEVELS-1, so level 0 is highest.
  - rotate_in_auto_eoi = 0.
  - eoi_error = 0.
  - Internal last_acked = 0.
- Priority order: level (priority_rotate+1+k) mod NUM_LEVELS has rank k, where 0 is highest. The index sum wraps modulo NUM_LEVELS.
- Set: on a start_in_service edge, ISR |= interrupt and last_acked <= interrupt. Latency is 1 cycle.
- ocw2_cmd decode, applied only when ocw2_write = 1:
  - 001 non-specific EOI: clear the highest_level_in_service bit.
  - 011 specific EOI: clear bit ocw2_level.
  - 101 rotate on non-specific EOI: clear the highest bit, and set priority_rotate to that level.
  - 111 rotate on specific EOI: clear bit ocw2_level, and set priority_rotate to ocw2_level.
  - 110 set priority: priority_rotate <= ocw2_level; ISR unchanged.
  - 100: set rotate_in_auto_eoi.
  - 000: clear rotate_in_auto_eoi.
  - 010: no operation.
- EOI error case: an EOI command (001/011/101/111) whose target bit is 0, or a non-specific EOI with ISR empty. Required response:
  - eoi_error = 1 for exactly the next cycle.
  - ISR and priority_rotate are not changed.
- AEOI: when auto_eoi_mode = 1 and end_of_acknowledge_sequence = 1:
  - Clear the ISR bits given by last_acked.
  - If rotate_in_auto_eoi = 1, also set priority_rotate to the index of last_acked.
  - If last_acked = 0, this is a no-op with no error.
- Simultaneous events in the same cycle:
  - Clears are computed from the pre-edge ISR, and the next ISR is (ISR & ~clear) | set. Set wins on the same bit.
  - If an OCW2 rotation and an AEOI rotation coincide, the OCW2 rotation wins.
- Reset asserted mid-sequence returns all state to reset values immediately (asynchronous); no pending strobe survives.
- Inputs are assumed glitch-free and synchronous to clock. A multi-hot interrupt is illegal; the bench flags it with an assertion.

Decomposition:
- Shared package kf8259_common_pkg holds:
  - the ocw2_cmd encoding as an enum;
  - rotate-left/right-by-n functions parametrised on width;
  - a one-hot-to-index function.
- One sub-module, kf8259_priority_resolver (parameter NUM_LEVELS). It is purely combinational: rotate the request by priority_rotate+1, isolate the lowest set bit, rotate back. It produces highest_level_in_service and is reusable for the IRR path.

Test Plan:
1. Reset, check -> ISR=0x00, priority_rotate=7, rotate_in_auto_eoi=0, highest=0x00.
2. Acknowledge 0x80,0x40,…,0x01, then eight non-specific EOIs -> ISR=0xFF and highest=0x01 after the acks; EOIs clear bits 0..7 in order, ending at ISR=0x00, no eoi_error.
3. Set-priority with level 3, then ack 0x01 and 0x10 -> highest=0x10; a non-specific EOI gives ISR=0x01.
4. ISR=0x04, then cmd 101 -> ISR=0x00, priority_rotate=2. Then ack 0x08 and 0x02 -> highest=0x08.
5. auto_eoi_mode=1, cmd 100, ack 0x20, then end_of_acknowledge_sequence -> bit 5 cleared next cycle, priority_rotate=5.
6. ISR=0x01, specific EOI level 6 -> eoi_error pulses for 1 cycle, ISR stays 0x01. A same-cycle ack 0x02 with non-specific EOI gives ISR=0x02. Repeat scenarios 2–4 with NUM_LEVELS=16, checking wrap at level 15->0.
